// File: rtl/fors_sign_seq.sv
`default_nettype none
// ============================================================================
// Module   : fors_sign_seq
// Purpose  : FORS sequencer. Extracts per-tree leaf indices from the message
//            digest, schedules the secret-leaf SHA-256 call (sign mode only)
//            and the authentication-path treehash for every tree, then
//            requests the roots thash into the FORS public key.
// Revision : 1.0  initial release
// ============================================================================
module fors_sign_seq #(
  parameter int FORS_HEIGHT = 14,
  parameter int FORS_TREES  = 22,
  parameter int MHASH_W     = 312,
  parameter int SK_LEN      = 54
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   mode,
  input  logic [MHASH_W-1:0]     mhash,
  input  logic [255:0]           sk_seed,
  input  logic [255:0]           wots_addr,
  output logic                   sha256_start,
  output logic                   sha256_1st,
  output logic                   sha256_final,
  output logic [255:0]           sha256_state,
  output logic [511:0]           sha256_data,
  output logic [6:0]             sha256_len,
  input  logic                   sha256_done,
  input  logic [255:0]           sha256_dout,
  output logic                   tree_start,
  output logic [FORS_HEIGHT-1:0] tree_leaf_idx,
  output logic [23:0]            tree_idx_offset,
  input  logic                   tree_done,
  output logic                   pk_start,
  input  logic                   pk_done,
  output logic                   sig_vld,
  output logic [255:0]           dout,
  output logic [4:0]             tree_cnt,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_IDX    = 4'd1,
    S_SKREQ  = 4'd2,
    S_SKWAIT = 4'd3,
    S_TREQ   = 4'd4,
    S_TWAIT  = 4'd5,
    S_PKREQ  = 4'd6,
    S_PKWAIT = 4'd7,
    S_DONE   = 4'd8
  } state_e;

  localparam logic [255:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [4:0] LAST_TREE = 5'(FORS_TREES - 1);

  state_e               state_q;
  logic                 mode_q;
  logic [MHASH_W-1:0]   stream_q;     // digest reordered into an LSB-first bit stream
  logic [255:0]         sk_seed_q;
  logic [255:0]         wots_q;
  logic [4:0]           tree_cnt_q;
  logic [FORS_HEIGHT-1:0] leaf_q;
  logic [23:0]          offset_q;
  logic [511:0]         data_q;
  logic                 sha256_start_q;
  logic                 tree_start_q;
  logic                 pk_start_q;
  logic                 done_q;

  logic [MHASH_W-1:0]     stream_d;
  logic [9:0]             shamt_d;
  logic [FORS_HEIGHT-1:0] leaf_d;
  logic [23:0]            offset_d;
  logic [23:0]            tree_index_d;
  logic [255:0]           addr_d;
  logic                   unused_bits;

  // Stream bit k is bit (k mod 8) of digest byte k/8, byte 0 being the MSB byte.
  for (genvar k = 0; k < MHASH_W; k++) begin : g_stream
    assign stream_d[k] = mhash[MHASH_W-8-8*(k/8)+(k%8)];
  end

  assign shamt_d      = 10'(tree_cnt_q) * 10'(FORS_HEIGHT);
  assign leaf_d       = FORS_HEIGHT'(stream_q >> shamt_d);
  assign offset_d     = 24'(tree_cnt_q) << FORS_HEIGHT;
  assign tree_index_d = offset_d + 24'(leaf_d);
  assign addr_d       = {wots_q[255:184], 8'd3, wots_q[175:104], tree_index_d, wots_q[79:0]};
  assign unused_bits  = ^{wots_q[183:176], wots_q[103:80]};

  // Sequencer: state, tree counter, latched operands and registered pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= S_IDLE;
      mode_q         <= 1'b0;
      stream_q       <= '0;
      sk_seed_q      <= '0;
      wots_q         <= '0;
      tree_cnt_q     <= '0;
      leaf_q         <= '0;
      offset_q       <= '0;
      data_q         <= '0;
      sha256_start_q <= 1'b0;
      tree_start_q   <= 1'b0;
      pk_start_q     <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      sha256_start_q <= 1'b0;
      tree_start_q   <= 1'b0;
      pk_start_q     <= 1'b0;
      done_q         <= 1'b0;
      if (abort) begin
        state_q    <= S_IDLE;
        tree_cnt_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              mode_q     <= mode;
              stream_q   <= stream_d;
              sk_seed_q  <= sk_seed;
              wots_q     <= wots_addr;
              tree_cnt_q <= '0;
              state_q    <= S_IDX;
            end
          end
          S_IDX: begin
            leaf_q   <= leaf_d;
            offset_q <= offset_d;
            data_q   <= {sk_seed_q, addr_d};
            if (!mode_q) begin
              sha256_start_q <= 1'b1;
              state_q        <= S_SKREQ;
            end else begin
              tree_start_q <= 1'b1;
              state_q      <= S_TREQ;
            end
          end
          S_SKREQ:  state_q <= S_SKWAIT;
          S_SKWAIT: begin
            if (sha256_done) begin
              tree_start_q <= 1'b1;
              state_q      <= S_TREQ;
            end
          end
          S_TREQ:   state_q <= S_TWAIT;
          S_TWAIT: begin
            if (tree_done) begin
              if (tree_cnt_q == LAST_TREE) begin
                pk_start_q <= 1'b1;
                state_q    <= S_PKREQ;
              end else begin
                tree_cnt_q <= tree_cnt_q + 5'd1;
                state_q    <= S_IDX;
              end
            end
          end
          S_PKREQ:  state_q <= S_PKWAIT;
          S_PKWAIT: begin
            if (pk_done) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
          S_DONE:   state_q <= S_IDLE;
          default:  state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign sha256_start    = sha256_start_q;
  assign sha256_1st      = sha256_start_q;
  assign sha256_final    = sha256_start_q;
  assign sha256_state    = SHA256_IV;
  assign sha256_data     = data_q;
  assign sha256_len      = 7'(SK_LEN);
  assign tree_start      = tree_start_q;
  assign tree_leaf_idx   = leaf_q;
  assign tree_idx_offset = offset_q;
  assign pk_start        = pk_start_q;
  assign sig_vld         = (state_q == S_SKWAIT) && sha256_done;
  assign dout            = sig_vld ? sha256_dout : '0;
  assign tree_cnt        = tree_cnt_q;
  assign busy            = (state_q != S_IDLE);
  assign done            = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fors_sign_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fors_sign_seq
// Purpose  : Directed self-checking bench for fors_sign_seq (default geometry
//            plus a second 12x14 instance over a 168-bit digest).
// Revision : 1.0  initial release
// ============================================================================
module tb_fors_sign_seq;

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] DOUT_PAT = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main instance (14 x 22, 312-bit digest) ----------------
  logic         rstn = 1'b0, start = 1'b0, abort = 1'b0, mode = 1'b0;
  logic [311:0] mhash = '0;
  logic [255:0] sk_seed = '0, wots_addr = '0;
  logic         sha256_start, sha256_1st, sha256_final;
  logic [255:0] sha256_state;
  logic [511:0] sha256_data;
  logic [6:0]   sha256_len;
  logic         sha256_done, tree_done, pk_done;
  logic         tree_start, pk_start, sig_vld, busy, done;
  logic [13:0]  tree_leaf_idx;
  logic [23:0]  tree_idx_offset;
  logic [255:0] dout;
  logic [4:0]   tree_cnt;

  logic auto = 1'b0, man_sha = 1'b0, man_tree = 1'b0, man_pk = 1'b0;
  logic rsp_sha = 1'b0, rsp_tree = 1'b0;
  assign sha256_done = auto ? rsp_sha  : man_sha;
  assign tree_done   = auto ? rsp_tree : man_tree;
  assign pk_done     = man_pk;

  fors_sign_seq u_dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .mode(mode),
    .mhash(mhash), .sk_seed(sk_seed), .wots_addr(wots_addr),
    .sha256_start(sha256_start), .sha256_1st(sha256_1st), .sha256_final(sha256_final),
    .sha256_state(sha256_state), .sha256_data(sha256_data), .sha256_len(sha256_len),
    .sha256_done(sha256_done), .sha256_dout(DOUT_PAT),
    .tree_start(tree_start), .tree_leaf_idx(tree_leaf_idx), .tree_idx_offset(tree_idx_offset),
    .tree_done(tree_done), .pk_start(pk_start), .pk_done(pk_done),
    .sig_vld(sig_vld), .dout(dout), .tree_cnt(tree_cnt), .busy(busy), .done(done)
  );

  // ---------------- second instance (12 x 14, 168-bit digest) ----------------
  logic         start2 = 1'b0;
  logic [167:0] mhash2 = '0;
  logic         s2_sha_start, s2_1st, s2_final, s2_tree_start, s2_pk_start;
  logic [255:0] s2_state, s2_dout;
  logic [511:0] s2_data;
  logic [6:0]   s2_len;
  logic [11:0]  s2_leaf;
  logic [23:0]  s2_off;
  logic         s2_sig_vld, s2_busy, s2_done;
  logic [4:0]   s2_cnt;
  logic         s2_sha_done = 1'b0, s2_tree_done = 1'b0, s2_pk_done = 1'b0;

  fors_sign_seq #(.FORS_HEIGHT(12), .FORS_TREES(14), .MHASH_W(168), .SK_LEN(54)) u_dut2 (
    .clk(clk), .rstn(rstn), .start(start2), .abort(1'b0), .mode(1'b0),
    .mhash(mhash2), .sk_seed(256'h5eed), .wots_addr(256'h0),
    .sha256_start(s2_sha_start), .sha256_1st(s2_1st), .sha256_final(s2_final),
    .sha256_state(s2_state), .sha256_data(s2_data), .sha256_len(s2_len),
    .sha256_done(s2_sha_done), .sha256_dout(DOUT_PAT),
    .tree_start(s2_tree_start), .tree_leaf_idx(s2_leaf), .tree_idx_offset(s2_off),
    .tree_done(s2_tree_done), .pk_start(s2_pk_start), .pk_done(s2_pk_done),
    .sig_vld(s2_sig_vld), .dout(s2_dout), .tree_cnt(s2_cnt), .busy(s2_busy), .done(s2_done)
  );

  // Zero-latency responders: answer in the cycle after each request pulse.
  always @(posedge clk) begin
    rsp_sha      <= sha256_start;
    rsp_tree     <= tree_start;
    s2_sha_done  <= s2_sha_start;
    s2_tree_done <= s2_tree_start;
    s2_pk_done   <= s2_pk_start;
  end

  // Reference leaf index: bit j of index i is digest bit offset i*fh+j, LSB-first per byte.
  function automatic logic [23:0] ref_leaf(input logic [311:0] mh, input int mw, input int fh, input int i);
    logic [23:0] r;
    r = '0;
    for (int j = 0; j < fh; j++) begin
      int k;
      k = i * fh + j;
      r[j] = mh[mw - 8 - 8 * (k >> 3) + (k & 7)];
    end
    return r;
  endfunction

  // Event monitors, sampled on the falling edge.
  logic clr = 1'b0;
  int n_sha, n_tree, n_pk, n_done, n_sig, n_tree2, n_sha2, n_done2;
  logic seq_ok, leaf_ok, sig_ok, leaf2_ok, off2_ok;
  logic [23:0] last_off, last_off2;
  always @(negedge clk) begin
    if (clr) begin
      n_sha <= 0; n_tree <= 0; n_pk <= 0; n_done <= 0; n_sig <= 0;
      n_tree2 <= 0; n_sha2 <= 0; n_done2 <= 0;
      seq_ok <= 1'b1; leaf_ok <= 1'b1; sig_ok <= 1'b1; leaf2_ok <= 1'b1; off2_ok <= 1'b1;
      last_off <= '0; last_off2 <= '0;
    end else begin
      if (sha256_start) n_sha <= n_sha + 1;
      if (pk_start) n_pk <= n_pk + 1;
      if (done) n_done <= n_done + 1;
      if (sig_vld) begin
        n_sig  <= n_sig + 1;
        sig_ok <= sig_ok & (dout == DOUT_PAT);
      end
      if (tree_start) begin
        n_tree   <= n_tree + 1;
        last_off <= tree_idx_offset;
        seq_ok   <= seq_ok & (tree_cnt == 5'(n_tree));
        leaf_ok  <= leaf_ok & (24'(tree_leaf_idx) == ref_leaf(mhash, 312, 14, int'(tree_cnt)));
      end
      if (s2_sha_start) n_sha2 <= n_sha2 + 1;
      if (s2_done) n_done2 <= n_done2 + 1;
      if (s2_tree_start) begin
        n_tree2   <= n_tree2 + 1;
        last_off2 <= s2_off;
        leaf2_ok  <= leaf2_ok & (24'(s2_leaf) == ref_leaf({144'b0, mhash2}, 168, 12, n_tree2));
        off2_ok   <= off2_ok & (s2_off == (24'(n_tree2) << 12));
      end
    end
  end

  int n_total = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic launch(input logic m);
    @(posedge clk); #1;
    mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits (bounded) for pk_start, optionally offers an early pk_done in the
  // request cycle, then answers and checks done/busy timing.
  task automatic finish_pk(input bit early);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!pk_start && n < 3000);
    chk("pk_start_seen", pk_start, 1);
    if (early) begin
      man_pk = 1'b1;
      @(posedge clk); #1 man_pk = 1'b0;
      @(negedge clk); chk("early_pk_done_ignored", done, 0);
    end
    @(posedge clk); #1 man_pk = 1'b1;
    @(negedge clk); chk("done_low_at_P", {done, busy}, 2'b01);
    @(posedge clk); #1 man_pk = 1'b0;
    @(negedge clk); chk("done_at_P1", {done, busy}, 2'b11);
    @(negedge clk); chk("idle_at_P2", {done, busy}, 2'b00);
  endtask

  task automatic wait_tree(input logic [4:0] c);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!(tree_start && tree_cnt == c) && n < 3000);
    chk("tree_start_seen", {tree_start, tree_cnt}, {1'b1, c});
  endtask

  logic [319:0] rnd;

  initial begin
    for (int w = 0; w < 10; w++) rnd[w*32 +: 32] = $urandom;
    mhash = rnd[311:0];
    mhash[311:304] = 8'hAB;
    mhash[303:296] = 8'hCD;
    sk_seed   = {8{32'h5eed1234}};
    wots_addr = {8{32'hA5A55A5A}};
    clear_counts();

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_pulses", {sha256_start, tree_start, pk_start, done, sig_vld, busy}, 6'b0);
    chk("rst_tree_cnt", tree_cnt, 0);
    chk("rst_data", {sha256_data, tree_leaf_idx}, 0);
    chk("rst_dout", dout, 0);
    chk("sha_iv", sha256_state, IV);
    @(posedge clk); #1 rstn = 1'b1;
    clear_counts();

    // ---- sign, tree 0 by hand ----
    launch(1'b0);                                      // now in T+1
    @(negedge clk); chk("busy_T1", {busy, sha256_start, tree_start}, 3'b100);
    @(posedge clk); #1 man_sha = 1'b1;                 // T+2, same-cycle done
    @(negedge clk);
    chk("sha_req_T2", {sha256_start, sha256_1st, sha256_final}, 3'b111);
    chk("sha_len", sha256_len, 54);
    chk("leaf0", tree_leaf_idx, 14'h0DAB);
    chk("addr_tree_idx", sha256_data[103:80], 24'h000DAB);
    chk("addr_type", sha256_data[183:176], 8'd3);
    chk("addr_wots", {sha256_data[255:184], sha256_data[175:104], sha256_data[79:0]},
        {wots_addr[255:184], wots_addr[175:104], wots_addr[79:0]});
    chk("data_seed", sha256_data[511:256], sk_seed);
    chk("no_sig_in_req", sig_vld, 0);
    @(posedge clk); #1 man_sha = 1'b0; man_tree = 1'b1;  // T+3 spurious tree_done
    @(negedge clk); chk("early_sha_done_ignored", {tree_start, busy}, 2'b01);
    @(posedge clk); #1 man_tree = 1'b0; man_sha = 1'b1; start = 1'b1;  // T+4
    @(negedge clk); chk("sig_beat", {sig_vld, dout}, {1'b1, DOUT_PAT});
    chk("spurious_tree_ignored", {tree_start, tree_cnt}, 0);
    @(posedge clk); #1 man_sha = 1'b0; start = 1'b0;   // T+5
    @(negedge clk); chk("tree_req_D1", {tree_start, tree_cnt}, {1'b1, 5'd0});
    @(posedge clk); #1;                                // T+6
    @(posedge clk); #1 man_tree = 1'b1;                // T+7
    @(posedge clk); #1 man_tree = 1'b0;                // T+8 S_IDX
    @(negedge clk); chk("idx_cnt1", {tree_cnt, sha256_start}, {5'd1, 1'b0});
    @(negedge clk); chk("sha_req_D2", sha256_start, 1);
    chk("leaf1", 24'(tree_leaf_idx), ref_leaf(mhash, 312, 14, 1));
    chk("offset1", tree_idx_offset, 24'h004000);
    @(posedge clk); #1 auto = 1'b1;
    finish_pk(1'b0);
    chk("sign_counts", {n_sha[7:0], n_tree[7:0], n_pk[7:0], n_done[7:0], n_sig[7:0]},
        {8'd22, 8'd22, 8'd1, 8'd1, 8'd22});
    chk("sign_seq_leaf", {seq_ok, leaf_ok, sig_ok}, 3'b111);
    chk("last_offset", last_off, 24'h054000);

    // ---- verify mode ----
    clear_counts();
    launch(1'b1);
    @(negedge clk); chk("vfy_busy_T1", {busy, tree_start}, 2'b10);
    @(negedge clk); chk("vfy_tree_T2", {tree_start, sha256_start}, 2'b10);
    finish_pk(1'b1);
    chk("vfy_counts", {n_sha[7:0], n_tree[7:0], n_pk[7:0], n_done[7:0]},
        {8'd0, 8'd22, 8'd1, 8'd1});
    chk("vfy_seq_leaf", {seq_ok, leaf_ok}, 2'b11);

    // ---- abort in S_TWAIT of tree 5 ----
    clear_counts();
    launch(1'b0);
    wait_tree(5'd5);
    @(posedge clk); #1 abort = 1'b1;                   // TWAIT, tree_done also high
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk); chk("abort_idle", {busy, tree_cnt, tree_start, sha256_start, pk_start}, 0);
    repeat (10) @(negedge clk);
    chk("abort_no_done", {n_done[7:0], 1'b0, busy}, 0);
    clear_counts();
    launch(1'b0);
    finish_pk(1'b0);
    chk("rerun_counts", {n_sha[7:0], n_tree[7:0], n_pk[7:0], n_done[7:0]},
        {8'd22, 8'd22, 8'd1, 8'd1});
    chk("rerun_seq", seq_ok, 1);

    // ---- asynchronous reset mid-run ----
    launch(1'b0);
    wait_tree(5'd3);
    @(posedge clk); #1 rstn = 1'b0;
    #1 chk("rstn_async", {busy, tree_cnt, sha256_data, tree_leaf_idx, tree_idx_offset}, 0);
    @(negedge clk);
    chk("rstn_pulses", {sha256_start, tree_start, pk_start, done, sig_vld, dout}, 0);
    @(posedge clk); #1 rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstn_stays_idle", busy, 0);

    // ---- 12 x 14 geometry over a 168-bit random digest ----
    auto = 1'b0;
    for (int w = 0; w < 6; w++) rnd[w*32 +: 32] = $urandom;
    mhash2 = rnd[167:0];
    clear_counts();
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!s2_done && n < 3000);
    end
    @(negedge clk);
    chk("g12_counts", {n_tree2[7:0], n_sha2[7:0], n_done2[7:0], s2_busy}, {8'd14, 8'd14, 8'd1, 1'b0});
    chk("g12_leaf_off", {leaf2_ok, off2_ok}, 2'b11);
    chk("g12_last_off", last_off2, 24'h00D000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
